// File: rtl/rpsc_pkg.sv
// Shared definitions for the RPSC fault controller.
//   fault_ctrl_state_t : controller FSM states
//   N_FAULTS           : number of latched fault lines (FF17..FF24)
//   DEF_*_CYC          : default timing constants in clock cycles
package rpsc_pkg;

  localparam int unsigned N_FAULTS          = 8;
  localparam int unsigned DEF_RST_PULSE_CYC = 4;
  localparam int unsigned DEF_HOLDOFF_CYC   = 8;
  localparam int unsigned DEF_LAMP_CYC      = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FAULT     = 3'd1,
    RST_PULSE = 3'd2,
    HOLDOFF   = 3'd3,
    LAMP      = 3'd4
  } fault_ctrl_state_t;

endpackage

// File: rtl/rpsc_prio_enc8.sv
// 8-bit priority encoder, lowest set index wins.
//   vec   : input vector
//   idx   : index of the lowest set bit (0 when vec == 0)
//   valid : at least one bit of vec is set
module rpsc_prio_enc8 (
  input  logic [7:0] vec,
  output logic [2:0] idx,
  output logic       valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (vec[i] && !valid) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rpsc_fault_ctrl.sv
// RPSC first-fault capture, fault-reset pulse and lamp-test controller.
//   clk, reset       : clock, asynchronous active-high reset
//   fault_la         : latched fault lines FF17..FF24 (bit0 = FF17)
//   reset_req        : operator fault-reset request (level, edge detected)
//   lamp_req         : operator lamp-test request (level, edge detected)
//   reset_hold_error : clear pulse to the hold-error latches
//   LA_Test          : lamp-test drive to the latches
//   first_fault      : index of the first captured fault
//   first_valid      : first_fault holds a valid capture
//   any_fault        : registered OR of fault_la
//   trip_count       : saturating count of first-fault captures
module rpsc_fault_ctrl
  import rpsc_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC = DEF_RST_PULSE_CYC,
  parameter int unsigned HOLDOFF_CYC   = DEF_HOLDOFF_CYC,
  parameter int unsigned LAMP_CYC      = DEF_LAMP_CYC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FAULTS-1:0] fault_la,
  input  logic                reset_req,
  input  logic                lamp_req,
  output logic                reset_hold_error,
  output logic                LA_Test,
  output logic [2:0]          first_fault,
  output logic                first_valid,
  output logic                any_fault,
  output logic [7:0]          trip_count
);

  fault_ctrl_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       reset_req_q, lamp_req_q;
  logic       lamp_ret_q, lamp_ret_d;   // 1: LAMP was entered from FAULT
  logic [2:0] first_fault_q, first_fault_d;
  logic       first_valid_q, first_valid_d;
  logic [7:0] trip_count_q, trip_count_d;
  logic       any_fault_q;

  logic       rst_edge, lamp_edge;
  logic [2:0] enc_idx;
  logic       enc_valid;

  rpsc_prio_enc8 u_enc (
    .vec   (fault_la),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign rst_edge  = reset_req & ~reset_req_q;
  assign lamp_edge = lamp_req  & ~lamp_req_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lamp_ret_d    = lamp_ret_q;
    first_fault_d = first_fault_q;
    first_valid_d = first_valid_q;
    trip_count_d  = trip_count_q;

    unique case (state_q)
      IDLE, FAULT: begin
        // Reset edge beats lamp edge; either beats a same-cycle capture.
        if (rst_edge) begin
          state_d       = RST_PULSE;
          cnt_d         = 8'(RST_PULSE_CYC - 1);
          first_valid_d = 1'b0;
        end else if (lamp_edge) begin
          state_d    = LAMP;
          cnt_d      = 8'(LAMP_CYC - 1);
          lamp_ret_d = (state_q == FAULT);
        end else if (state_q == IDLE && enc_valid) begin
          state_d       = FAULT;
          first_fault_d = enc_idx;
          first_valid_d = 1'b1;
          if (trip_count_q != 8'hFF) trip_count_d = trip_count_q + 8'd1;
        end
      end
      RST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLDOFF;
          cnt_d   = 8'(HOLDOFF_CYC - 1);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLDOFF: begin
        if (cnt_q == '0) begin
          if (enc_valid) begin
            state_d       = FAULT;
            first_fault_d = enc_idx;
            first_valid_d = 1'b1;
            if (trip_count_q != 8'hFF) trip_count_d = trip_count_q + 8'd1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      LAMP: begin
        if (cnt_q == '0) state_d = lamp_ret_q ? FAULT : IDLE;
        else             cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      reset_req_q   <= 1'b0;
      lamp_req_q    <= 1'b0;
      lamp_ret_q    <= 1'b0;
      first_fault_q <= '0;
      first_valid_q <= 1'b0;
      trip_count_q  <= '0;
      any_fault_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reset_req_q   <= reset_req;
      lamp_req_q    <= lamp_req;
      lamp_ret_q    <= lamp_ret_d;
      first_fault_q <= first_fault_d;
      first_valid_q <= first_valid_d;
      trip_count_q  <= trip_count_d;
      any_fault_q   <= |fault_la;
    end
  end

  // Moore decode from the state flop, so reset drops both immediately.
  assign reset_hold_error = (state_q == RST_PULSE);
  assign LA_Test          = (state_q == LAMP);
  assign first_fault      = first_fault_q;
  assign first_valid      = first_valid_q;
  assign any_fault        = any_fault_q;
  assign trip_count       = trip_count_q;

endmodule

// File: doc/rpsc_fault_ctrl.md
RPSC_FAULT_CTRL -- requirements
Module: rpsc_fault_ctrl

Interface
REQ-001 The block SHALL have parameter RST_PULSE_CYC, default 4, giving the reset_hold_error pulse length in cycles (range 1-255).
REQ-002 The block SHALL have parameter HOLDOFF_CYC, default 8, giving the post-reset settle time in cycles (range 1-255).
REQ-003 The block SHALL have parameter LAMP_CYC, default 16, giving the lamp-test duration in cycles (range 1-255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port fault_la, input, 8 bits: latched fault lines FF17..FF24 (bit0 = FF17).
REQ-007 The block SHALL have port reset_req, input, 1 bit: operator fault-reset request, synchronous level.
REQ-008 The block SHALL have port lamp_req, input, 1 bit: operator lamp-test request, synchronous level.
REQ-009 The block SHALL have port reset_hold_error, output, 1 bit: clear pulse to the hold-error latches.
REQ-010 The block SHALL have port LA_Test, output, 1 bit: lamp-test drive to the latches.
REQ-011 The block SHALL have port first_fault, output, 3 bits: index of the first captured fault.
REQ-012 The block SHALL have port first_valid, output, 1 bit: first_fault holds a valid capture.
REQ-013 The block SHALL have port any_fault, output, 1 bit: registered OR of fault_la.
REQ-014 The block SHALL have port trip_count, output, 8 bits: number of first-fault captures, saturating.

Function
REQ-015 The block SHALL implement the FSM states IDLE, FAULT, RST_PULSE, HOLDOFF and LAMP, all Moore-decoded from the registered state.
REQ-016 The block SHALL detect request edges as req & ~req_q, using one register per request.
REQ-017 In IDLE, when fault_la != 0, the block SHALL capture the lowest set bit index into first_fault, set first_valid, increment trip_count (saturating at 255) and go to FAULT; all of this SHALL be visible on the next cycle.
REQ-018 In FAULT, the block SHALL hold first_fault and ignore further faults.
REQ-019 In IDLE or FAULT, a reset_req edge SHALL transition the FSM to RST_PULSE; a lamp_req edge SHALL transition it to LAMP; when both edges occur in the same cycle, the reset edge SHALL win and the lamp edge SHALL be dropped.
REQ-020 An IDLE cycle that has a fault and a request edge together SHALL take the request; the capture SHALL not occur in that cycle.
REQ-021 reset_hold_error SHALL be 1 in RST_PULSE, for exactly RST_PULSE_CYC cycles; the block SHALL then go to HOLDOFF and clear first_valid on entry to RST_PULSE.
REQ-022 HOLDOFF SHALL last exactly HOLDOFF_CYC cycles, ignoring faults and requests; on exit it SHALL go to FAULT with a fresh capture if fault_la != 0 in its last cycle, otherwise to IDLE.
REQ-023 LA_Test SHALL be 1 in LAMP, for exactly LAMP_CYC cycles; faults and requests SHALL be ignored in LAMP, first_fault and first_valid SHALL be frozen, and the block SHALL then return to the state it entered LAMP from.
REQ-024 Request edges arriving while in RST_PULSE, HOLDOFF or LAMP SHALL be discarded, not queued.
REQ-025 A single shared 8-bit down-counter SHALL time RST_PULSE, HOLDOFF and LAMP; it SHALL be loaded with N-1 on state entry and exit the state at 0.
REQ-026 any_fault SHALL be registered, one cycle of latency.

Reset
REQ-027 Asynchronous reset SHALL force the state to IDLE; every output (reset_hold_error, LA_Test, first_fault, first_valid, any_fault, trip_count) to 0; the counter to 0; and the request edge registers to 0.
REQ-028 Reset asserted mid-pulse or mid-lamp-test SHALL drop reset_hold_error and LA_Test immediately (combinationally via the flops), with no pulse completion after release.

Structure
REQ-029 Package rpsc_pkg SHALL hold the state enum fault_ctrl_state_t, the constant N_FAULTS = 8 and the default cycle constants.
REQ-030 One sub-module, rpsc_prio_enc8 (8-bit lowest-index priority encoder, outputs idx[2:0] and valid), SHALL be instantiated; all other logic SHALL be inline.

Verification
REQ-031 Directed scenario: fault_la = 8'b0010_0100 from IDLE -> the next cycle shows first_fault = 2, first_valid = 1, trip_count = 1, state FAULT; a later bit0 SHALL leave first_fault = 2.
REQ-032 Directed scenario: reset_req rising in FAULT, fault cleared -> reset_hold_error high for exactly 4 cycles, then 8 HOLDOFF cycles, then IDLE with first_valid = 0.
REQ-033 Directed scenario: fault persisting through HOLDOFF with fault_la = 8'h80 -> FAULT with first_fault = 7 and trip_count incremented.
REQ-034 Directed scenario: reset_req and lamp_req edges in the same cycle -> only the reset pulse; LA_Test stays 0; holding lamp_req high afterwards SHALL produce no lamp test.
REQ-035 Directed scenario: lamp_req from FAULT -> LA_Test high for 16 cycles with first_fault unchanged, then return to FAULT; reset asserted at lamp cycle 5 -> LA_Test = 0 immediately, IDLE after release.
REQ-036 Directed scenario: 260 capture/reset cycles -> trip_count saturates at 255.
